// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - control-flow unit: branch decode, return stack, loop counter, halt
// Optional loop counter (LDLOOP/LOOP) is built only when BRU_LOOP_EN is defined.
module branch_unit #(
  parameter int STACK_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [7:0]                           addr,
  input  logic [15:0]                          instr,
  input  logic                                 instr_valid,
  input  logic                                 zf,
  input  logic                                 cf,
  output logic                                 jump,
  output logic [7:0]                           jumpaddr,
  output logic                                 halted,
  output logic                                 stack_err,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     sp
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t     state, state_next;
  logic [7:0] halt_addr;
  // Shift-register stack: entry 0 is always the top of stack.
  logic [7:0] stack [STACK_DEPTH];

  logic [3:0] opcode;
  logic [7:0] imm;
  logic       do_push, do_pop, set_err, go_halt;
  logic       unused_bits;

  assign opcode      = instr[15:12];
  assign imm         = instr[7:0];
  assign unused_bits = ^instr[11:8];

`ifdef BRU_LOOP_EN
  logic [7:0] loop_cnt;
  logic       cnt_load, cnt_dec;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == RUN && go_halt) state_next = HALT;
  end

  // Decode: combinational jump/jumpaddr plus the side effects to commit at the edge.
  always_comb begin
    jump     = 1'b0;
    jumpaddr = 8'h00;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    set_err  = 1'b0;
    go_halt  = 1'b0;
`ifdef BRU_LOOP_EN
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`endif
    if (!rst) begin
      jump = 1'b0;
    end else if (state == HALT) begin
      jump     = 1'b1;
      jumpaddr = halt_addr;
    end else if (instr_valid) begin
      case (opcode)
        4'h8: begin
          jump     = 1'b1;
          jumpaddr = imm;
        end
        4'h9: if (zf) begin
          jump     = 1'b1;
          jumpaddr = imm;
        end
        4'hA: if (cf) begin
          jump     = 1'b1;
          jumpaddr = imm;
        end
        4'hB: begin
          jump     = 1'b1;
          jumpaddr = imm;
          if (sp == SP_FULL) set_err = 1'b1;
          else               do_push = 1'b1;
        end
        4'hC: begin
          if (sp == '0) begin
            set_err = 1'b1;
          end else begin
            jump     = 1'b1;
            jumpaddr = stack[0];
            do_pop   = 1'b1;
          end
        end
`ifdef BRU_LOOP_EN
        4'hD: cnt_load = 1'b1;
        4'hE: if (loop_cnt != 8'h00) begin
          jump     = 1'b1;
          jumpaddr = imm;
          cnt_dec  = 1'b1;
        end
`endif
        4'hF: begin
          jump     = 1'b1;
          jumpaddr = addr;
          go_halt  = 1'b1;
        end
        default: jump = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp        <= '0;
      stack_err <= 1'b0;
      halt_addr <= 8'h00;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= 8'h00;
    end else begin
      if (set_err) stack_err <= 1'b1;
      if (go_halt) halt_addr <= addr;
      if (do_push) begin
        // 8-bit wrap so a CALL at 0xFF returns to 0x00, like pc does.
        stack[0] <= addr + 8'd1;
        for (int i = 1; i < STACK_DEPTH; i++) stack[i] <= stack[i-1];
        sp <= sp + 1'b1;
      end else if (do_pop) begin
        for (int i = 0; i < STACK_DEPTH - 1; i++) stack[i] <= stack[i+1];
        stack[STACK_DEPTH-1] <= 8'h00;
        sp <= sp - 1'b1;
      end
    end
  end

`ifdef BRU_LOOP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          loop_cnt <= 8'h00;
    else if (cnt_load) loop_cnt <= imm;
    else if (cnt_dec)  loop_cnt <= loop_cnt - 8'd1;
  end
`endif

  assign halted = (state == HALT);

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - randomized self-checking bench for branch_unit against a queue-based model
module tb_branch_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [7:0]  addr;
  logic [15:0] instr;
  logic        instr_valid;
  logic        zf;
  logic        cf;
  logic        jump;
  logic [7:0]  jumpaddr;
  logic        halted;
  logic        stack_err;
  logic [$clog2(DEPTH+1)-1:0] sp;

  branch_unit #(.STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .addr(addr), .instr(instr), .instr_valid(instr_valid),
    .zf(zf), .cf(cf), .jump(jump), .jumpaddr(jumpaddr), .halted(halted),
    .stack_err(stack_err), .sp(sp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] m_stack [$];
  int         m_cnt;
  bit         m_halt;
  logic [7:0] m_haddr;
  bit         m_err;
  int         halt_cycles;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stack.delete();
    m_cnt   = 0;
    m_halt  = 0;
    m_haddr = 8'h00;
    m_err   = 0;
    halt_cycles = 0;
  endtask

  // Called just after a posedge; asserts reset, checks outputs asynchronously, releases it.
  task automatic do_reset();
    instr_valid = 1'b1;
    instr = 16'h8042;
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_jump", 32'(jump), 0);
    check("rst_jumpaddr", 32'(jumpaddr), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_sp", 32'(sp), 0);
    check("rst_stack_err", 32'(stack_err), 0);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic step(input logic [7:0] a, input logic [15:0] ins, input logic v,
                      input logic z, input logic c);
    logic       ej;
    logic [7:0] ea;
    int         op;
    logic [7:0] imm;
    addr = a; instr = ins; instr_valid = v; zf = z; cf = c;
    #2;
    check("halted", 32'(halted), 32'(m_halt));
    check("sp", 32'(sp), 32'(m_stack.size()));
    check("stack_err", 32'(stack_err), 32'(m_err));
    ej = 0; ea = 8'h00;
    op = int'(ins[15:12]);
    imm = ins[7:0];
    if (m_halt) begin
      ej = 1; ea = m_haddr; halt_cycles++;
    end else if (v) begin
      case (op)
        8:  begin ej = 1; ea = imm; end
        9:  if (z) begin ej = 1; ea = imm; end
        10: if (c) begin ej = 1; ea = imm; end
        11: begin
          ej = 1; ea = imm;
          if (m_stack.size() == DEPTH) m_err = 1;
          else m_stack.push_front(8'((int'(a) + 1) % 256));
        end
        12: begin
          if (m_stack.size() == 0) m_err = 1;
          else begin ej = 1; ea = m_stack.pop_front(); end
        end
`ifdef BRU_LOOP_EN
        13: m_cnt = int'(imm);
        14: if (m_cnt != 0) begin ej = 1; ea = imm; m_cnt = m_cnt - 1; end
`endif
        15: begin ej = 1; ea = a; m_halt = 1; m_haddr = a; end
        default: ;
      endcase
    end
    check("jump", 32'(jump), 32'(ej));
    check("jumpaddr", 32'(jumpaddr), 32'(ea));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; addr = 8'h00; instr = 16'h0000; instr_valid = 1'b0; zf = 1'b0; cf = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Directed: JMP, invalid, JZ, JC
    step(8'h10, 16'h8042, 1, 0, 0);
    step(8'h10, 16'h8042, 0, 0, 0);
    step(8'h11, 16'h9020, 1, 0, 0);
    step(8'h11, 16'h9020, 1, 1, 0);
    step(8'h12, 16'hA020, 1, 0, 0);
    step(8'h12, 16'hA020, 1, 0, 1);
    // Return-address wrap
    step(8'hFF, 16'hB030, 1, 0, 0);
    step(8'h30, 16'hC000, 1, 0, 0);
    // RET underflow, sticky error
    step(8'h00, 16'hC000, 1, 0, 0);
    step(8'h01, 16'h0000, 1, 0, 0);
    do_reset();
    // Overflow: five CALLs, then unwind
    for (int i = 0; i < 5; i++) step(8'(8'h20 + i), 16'hB050, 1, 0, 0);
    step(8'h50, 16'h0000, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(8'h50, 16'hC000, 1, 0, 0);
    // Loop counter
    step(8'h04, 16'hD003, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(8'h05, 16'hE005, 1, 0, 0);
    // HALT then reset mid-halt
    step(8'h77, 16'hF000, 1, 0, 0);
    step(8'h12, 16'h8033, 1, 1, 1);
    step(8'h13, 16'hC000, 0, 0, 0);
    do_reset();

    // Randomized
    for (int n = 0; n < 600; n++) begin
      logic [15:0] ins;
      logic [3:0]  op;
      if (m_halt && halt_cycles > 3) do_reset();
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'hB;
      ins = {op, 4'($urandom), 8'($urandom)};
      if (op == 4'hD) ins[7:0] = 8'($urandom_range(0, 4));
      step(8'($urandom), ins, ($urandom_range(0, 9) != 0), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
